invader_formation_ctrl: RTL and testbench

- Sequences the monster formation for the game datapath.
- Owns the shared formation x-base, shared y row and per-monster alive mask.
- Paces steps off a per-frame tick: marches horizontally, drops one row at each screen edge, reverses direction, detects wave clear and game over.
- Drives the monster positions consumed by the pixel-drawing logic; takes kill strobes from collision logic.

---
 rtl/invader_formation_ctrl.sv | 172 +++++++++++++++++
 tb/tb_invader_formation_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/invader_formation_ctrl.sv
// invader_formation_ctrl: marches, drops and reverses the monster formation; tracks kills, waves and game over.
// Optional macro SPEEDUP_EN shortens the step period by one frame per completed wave. Rev 1.0
`default_nettype none

module invader_formation_ctrl #(
  parameter int N_MONS       = 5,
  parameter int X_START      = 250,
  parameter int Y_START      = 100,
  parameter int SPACING      = 100,
  parameter int STEP_X       = 2,
  parameter int STEP_Y       = 10,
  parameter int HALF_W       = 5,
  parameter int X_MIN        = 150,
  parameter int X_MAX        = 780,
  parameter int Y_LIMIT      = 430,
  parameter int TICK_DIV     = 4,
  parameter int CLEAR_FRAMES = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 enable,
  input  logic [N_MONS-1:0]    kill,
  output logic [10*N_MONS-1:0] xpos_all,
  output logic [9:0]           ypos,
  output logic [N_MONS-1:0]    alive,
  output logic                 dir_right,
  output logic [3:0]           wave_num,
  output logic                 wave_clear,
  output logic                 game_over
);

  localparam int IW  = (N_MONS > 1) ? $clog2(N_MONS) : 1;
  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV + 1) : 1;
  localparam int CCW = (CLEAR_FRAMES > 1) ? $clog2(CLEAR_FRAMES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MARCH   = 3'd1,
    DESCEND = 3'd2,
    CLEAR   = 3'd3,
    OVER    = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [9:0]         xbase, xbase_n, ypos_n;
  logic [N_MONS-1:0]  alive_n, alive_kill;
  logic               dir_right_n, wave_clear_n, game_over_n;
  logic [3:0]         wave_num_n;
  logic [TCW-1:0]     tick_cnt, tick_cnt_n, period;
  logic [CCW-1:0]     clear_cnt, clear_cnt_n;
  logic [IW-1:0]      lidx, ridx;
  logic [10:0]        right_x, left_x, y_next;
  logic               right_block, left_block, running, tick_en, step_evt;

  for (genvar i = 0; i < N_MONS; i++) begin : g_xpos
    assign xpos_all[10*i +: 10] = xbase + 10'(i * SPACING);
  end

  // Leftmost / rightmost alive index from the registered (pre-kill) mask
  always_comb begin
    lidx = '0;
    ridx = '0;
    for (int i = N_MONS - 1; i >= 0; i--)
      if (alive[i]) lidx = IW'(i);
    for (int i = 0; i < N_MONS; i++)
      if (alive[i]) ridx = IW'(i);
  end

  assign right_x     = {1'b0, xbase} + 11'(int'(ridx) * SPACING) + 11'(STEP_X + HALF_W);
  assign left_x      = {1'b0, xbase} + 11'(int'(lidx) * SPACING);
  assign right_block = right_x > 11'(X_MAX);
  assign left_block  = left_x < 11'(X_MIN + STEP_X + HALF_W);
  assign y_next      = {1'b0, ypos} + 11'(STEP_Y);

`ifdef SPEEDUP_EN
  assign period = (int'(wave_num) >= TICK_DIV - 1) ? TCW'(1) : TCW'(TICK_DIV - int'(wave_num));
`else
  assign period = TCW'(TICK_DIV);
`endif

  assign running    = (state == MARCH) || (state == DESCEND);
  assign tick_en    = frame_tick & enable;
  assign step_evt   = tick_en & running & (tick_cnt == period - TCW'(1));
  assign alive_kill = alive & ~kill;

  always_comb begin
    state_n      = state;
    xbase_n      = xbase;
    ypos_n       = ypos;
    alive_n      = alive;
    dir_right_n  = dir_right;
    tick_cnt_n   = tick_cnt;
    clear_cnt_n  = clear_cnt;
    wave_num_n   = wave_num;
    wave_clear_n = 1'b0;
    game_over_n  = game_over;
    case (state)
      IDLE: if (enable) state_n = MARCH;
      MARCH, DESCEND: begin
        if (alive_kill == '0) begin
          // Wave cleared: this cycle's step is dropped and the formation reloads
          state_n      = CLEAR;
          wave_clear_n = 1'b1;
          wave_num_n   = (wave_num == 4'hF) ? wave_num : wave_num + 4'd1;
          xbase_n      = 10'(X_START);
          ypos_n       = 10'(Y_START);
          alive_n      = '1;
          dir_right_n  = 1'b1;
          tick_cnt_n   = '0;
          clear_cnt_n  = '0;
        end else begin
          alive_n = alive_kill;
          if (step_evt)     tick_cnt_n = '0;
          else if (tick_en) tick_cnt_n = tick_cnt + TCW'(1);
          if (step_evt && state == MARCH) begin
            if (dir_right ? right_block : left_block) state_n = DESCEND;
            else if (dir_right) xbase_n = xbase + 10'(STEP_X);
            else                xbase_n = xbase - 10'(STEP_X);
          end else if (step_evt) begin
            ypos_n      = y_next[9:0];
            dir_right_n = ~dir_right;
            if (y_next >= 11'(Y_LIMIT)) begin
              state_n     = OVER;
              game_over_n = 1'b1;
            end else begin
              state_n = MARCH;
            end
          end
        end
      end
      CLEAR: if (tick_en) begin
        if (clear_cnt == CCW'(CLEAR_FRAMES - 1)) begin
          state_n     = MARCH;
          clear_cnt_n = '0;
        end else begin
          clear_cnt_n = clear_cnt + CCW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      xbase      <= 10'(X_START);
      ypos       <= 10'(Y_START);
      alive      <= '1;
      dir_right  <= 1'b1;
      tick_cnt   <= '0;
      clear_cnt  <= '0;
      wave_num   <= '0;
      wave_clear <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_n;
      xbase      <= xbase_n;
      ypos       <= ypos_n;
      alive      <= alive_n;
      dir_right  <= dir_right_n;
      tick_cnt   <= tick_cnt_n;
      clear_cnt  <= clear_cnt_n;
      wave_num   <= wave_num_n;
      wave_clear <= wave_clear_n;
      game_over  <= game_over_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_invader_formation_ctrl.sv
// Directed bench for invader_formation_ctrl: march/descend timing, pause, wave clear, game over, async reset.
`default_nettype none

module tb_invader_formation_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        enable;
  logic        enable_go;
  logic [4:0]  kill;

  logic [49:0] xpos_all, xpos_go;
  logic [9:0]  ypos, ypos_go;
  logic [4:0]  alive, alive_go;
  logic        dir_right, dir_go;
  logic [3:0]  wave_num, wn_go;
  logic        wave_clear, wc_go;
  logic        game_over, go_go;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  invader_formation_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable), .kill(kill),
    .xpos_all(xpos_all), .ypos(ypos), .alive(alive), .dir_right(dir_right),
    .wave_num(wave_num), .wave_clear(wave_clear), .game_over(game_over)
  );

  // Narrow playfield: both directions are blocked from the start, so every march step descends
  invader_formation_ctrl #(.X_MIN(300), .X_MAX(600)) dut_go (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable_go), .kill(kill),
    .xpos_all(xpos_go), .ypos(ypos_go), .alive(alive_go), .dir_right(dir_go),
    .wave_num(wn_go), .wave_clear(wc_go), .game_over(go_go)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One frame tick every 8 clocks; returns 1 time unit after the tick's sampling edge
  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (7) @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; enable = 1'b0; enable_go = 1'b0; kill = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x0",    32'(xpos_all[9:0]),   32'd250);
    chk("rst_x4",    32'(xpos_all[49:40]), 32'd650);
    chk("rst_y",     32'(ypos),            32'd100);
    chk("rst_alive", 32'(alive),           32'h1F);
    chk("rst_dir",   32'(dir_right),       32'd1);
    chk("rst_wave",  32'(wave_num),        32'd0);
    chk("rst_clr",   32'(wave_clear),      32'd0);
    chk("rst_over",  32'(game_over),       32'd0);
    rst = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1;

    // Full march right: 62 steps to 374, then descend
    frames(248);
    chk("march_x0", 32'(xpos_all[9:0]),   32'd374);
    chk("march_x4", 32'(xpos_all[49:40]), 32'd774);
    frames(4);
    chk("blk_x0", 32'(xpos_all[9:0]), 32'd374);
    chk("blk_y",  32'(ypos),          32'd100);
    frames(4);
    chk("desc_y",   32'(ypos),          32'd110);
    chk("desc_dir", 32'(dir_right),     32'd0);
    chk("desc_x0",  32'(xpos_all[9:0]), 32'd374);

    // Pause with tick_cnt=2: next step two ticks after resume
    frames(2);
    enable = 1'b0;
    frames(20);
    chk("pause_x0", 32'(xpos_all[9:0]), 32'd374);
    enable = 1'b1;
    frames(1);
    chk("resume1_x0", 32'(xpos_all[9:0]), 32'd374);
    frames(1);
    chk("resume2_x0", 32'(xpos_all[9:0]), 32'd372);

    // Kill everything in one cycle
    @(posedge clk); #1 kill = 5'h1F;
    @(posedge clk); #1 kill = '0;
    chk("clr_pulse", 32'(wave_clear),    32'd1);
    chk("clr_wave",  32'(wave_num),      32'd1);
    chk("clr_x0",    32'(xpos_all[9:0]), 32'd250);
    chk("clr_y",     32'(ypos),          32'd100);
    chk("clr_alive", 32'(alive),         32'h1F);
    chk("clr_dir",   32'(dir_right),     32'd1);
    @(posedge clk); #1;
    chk("clr_pulse_end", 32'(wave_clear), 32'd0);
    frames(63);
    chk("clr_hold_x0", 32'(xpos_all[9:0]), 32'd250);
    frames(1);
    chk("clr_resume_x0", 32'(xpos_all[9:0]), 32'd252);

    // Game over on the narrowed instance: 33 descends of 10 from 100
    enable_go = 1'b1;
    @(posedge clk); #1;
    frames(260);
    chk("go_pre_y",    32'(ypos_go), 32'd420);
    chk("go_pre_flag", 32'(go_go),   32'd0);
    frames(4);
    chk("go_y",    32'(ypos_go), 32'd430);
    chk("go_flag", 32'(go_go),   32'd1);
    @(posedge clk); #1 kill = 5'h1F;
    @(posedge clk); #1 kill = '0;
    chk("go_kill_alive", 32'(alive_go), 32'h1F);
    chk("go_kill_clr",   32'(wc_go),    32'd0);
    chk("go_kill_wave",  32'(wn_go),    32'd0);
    frames(8);
    chk("go_frz_y",    32'(ypos_go),      32'd430);
    chk("go_frz_x0",   32'(xpos_go[9:0]), 32'd250);
    chk("go_frz_flag", 32'(go_go),        32'd1);

    // Rightmost monster killed: index 3 now sets the right edge (blocked once xbase > 473)
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("go_rst_flag", 32'(go_go), 32'd0);
    @(posedge clk); #1 kill = 5'b10000;
    @(posedge clk); #1 kill = '0;
    chk("k4_alive", 32'(alive), 32'h0F);
    frames(448);
    chk("k4_x0", 32'(xpos_all[9:0]), 32'd474);
    frames(4);
    chk("k4_blk_x0", 32'(xpos_all[9:0]), 32'd474);
    chk("k4_blk_y",  32'(ypos),          32'd100);

    // Asynchronous reset while in DESCEND, observed before the next clock edge
    #3 rst = 1'b1;
    #1;
    chk("arst_x0",    32'(xpos_all[9:0]),   32'd250);
    chk("arst_x4",    32'(xpos_all[49:40]), 32'd650);
    chk("arst_y",     32'(ypos),            32'd100);
    chk("arst_alive", 32'(alive),           32'h1F);
    chk("arst_dir",   32'(dir_right),       32'd1);
    chk("arst_over",  32'(game_over),       32'd0);
    @(posedge clk); #1 rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
